// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial add/subtract controller.
// Contents:
//   WIDTH_DEFAULT : default operand/result width
//   state_e       : controller states (IDLE, RUN, DONE)
//   cnt_width()   : bit counter width for a given operand width (at least 1)
package serial_add_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A 1-bit operand still needs a 1-bit counter so the port slice stays legal.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/ha_cell.sv
// Half-adder cell; two of these plus an OR form the per-bit full adder.
// Ports:
//   a, b : input bits
//   s    : sum bit (a ^ b)
//   c    : carry bit (a & b)
module ha_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor with valid/ready handshakes on both sides.
// Operands are captured in IDLE, processed LSB first over exactly WIDTH RUN
// cycles, and the result is held in DONE until the consumer accepts it.
// Build option: define SERIAL_ADD_SUB_EN to honour op (1 = a - b); without it
// op is ignored and only addition is built.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid, in_ready   : operand handshake
//   op, a, b             : operation select and operands
//   out_valid, out_ready : result handshake
//   sum, cout            : result and final carry (subtract: 1 = no borrow)
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e             state_q;
  state_e             state_d;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               in_ready_q;
  logic               out_valid_q;

  logic               last_bit;
  logic               bit_sum;
  logic               carry_d;
  logic [WIDTH:0]     acc_ext;
  logic [WIDTH-1:0]   acc_d;
  logic [WIDTH-1:0]   b_load;
  logic               carry_load;
  logic               ha0_s;
  logic               ha0_c;
  logic               ha1_c;

  // Subtraction folds into addition: invert b once at capture and seed carry=1.
`ifdef SERIAL_ADD_SUB_EN
  assign b_load     = b ^ {WIDTH{op}};
  assign carry_load = op;
`else
  logic unused_op;
  assign unused_op  = op;
  assign b_load     = b;
  assign carry_load = 1'b0;
`endif

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // Per-bit full adder on the current LSBs.
  ha_cell u_ha0 (
    .a (a_q[0]),
    .b (b_q[0]),
    .s (ha0_s),
    .c (ha0_c)
  );

  ha_cell u_ha1 (
    .a (ha0_s),
    .b (carry_q),
    .s (bit_sum),
    .c (ha1_c)
  );

  assign carry_d = ha0_c | ha1_c;

  // New sum bit enters at the MSB; after WIDTH shifts the LSB has reached bit 0.
  assign acc_ext = {bit_sum, acc_q};
  assign acc_d   = acc_ext[WIDTH:1];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_RUN;
      ST_RUN:  if (last_bit)  state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Handshake flags registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_DONE);
    end
  end

  // Operand shift registers, bit counter, carry and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b_load;
            carry_q <= carry_load;
            cnt_q   <= '0;
          end
        end
        ST_RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          acc_q   <= acc_d;
          carry_q <= carry_d;
          if (last_bit) begin
            sum_q  <= acc_d;
            cout_q <= carry_d;
            cnt_q  <= '0;
          end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: a transaction-level model predicts
// in_ready/out_valid/sum/cout every cycle; directed cases pin literal results.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: W-bit result plus carry out in bit W.
  function automatic logic [W:0] ref_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic o);
    logic [W:0] r;
    r = {1'b0, x} + {1'b0, y};
`ifdef SERIAL_ADD_SUB_EN
    if (o) r = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
`else
    if (o) r = {1'b0, x} + {1'b0, y};
`endif
    return r;
  endfunction

  // Transaction-level model: idle / busy for W cycles / holding result.
  bit         m_idle;
  bit         m_done;
  int         m_left;
  logic [W:0] m_pend;
  logic [W-1:0] m_sum;
  logic       m_cout;

  always @(posedge clk) begin
    if (rst) begin
      m_idle <= 1'b1;
      m_done <= 1'b0;
      m_left <= 0;
      m_sum  <= '0;
      m_cout <= 1'b0;
    end else if (m_idle) begin
      if (in_valid) begin
        m_pend <= ref_result(a, b, op);
        m_left <= W;
        m_idle <= 1'b0;
      end
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_sum  <= m_pend[W-1:0];
        m_cout <= m_pend[W];
      end
    end else if (m_done && out_ready) begin
      m_done <= 1'b0;
      m_idle <= 1'b1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 32'(in_ready), 32'(m_idle));
      check("out_valid", 32'(out_valid), 32'(m_done));
      check("sum", 32'(sum), 32'(m_sum));
      check("cout", 32'(cout), 32'(m_cout));
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic top,
                        input int hold, output logic [W-1:0] rs, output logic rc,
                        output int lat);
    int g;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 4 * W + 10) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    #1;
    in_valid = 1'b1;
    a = ta;
    b = tb_v;
    op = top;
    @(posedge clk);
    #1;
    // Garbage on the input side while busy must be ignored.
    in_valid = 1'($urandom_range(0, 1));
    a = W'($urandom);
    b = W'($urandom);
    op = 1'($urandom_range(0, 1));
    lat = 0;
    rs = '0;
    rc = 1'b0;
    while (lat < 4 * W + 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
    if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
    rs = sum;
    rc = cout;
    repeat (hold) begin
      @(negedge clk);
      #1;
      in_valid = 1'($urandom_range(0, 1));
      a = W'($urandom);
      b = W'($urandom);
    end
    #1;
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] rs;
    logic         rc;
    int           lat;
    int           seen;
    int           last_t;
    int           n_res;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rop;
    logic [W:0]   exp;
    int           hold;

    rst = 1'b1;
    in_valid = 1'b0;
    op = 1'b0;
    a = '0;
    b = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);

    // Basic add with a long hold in DONE.
    run_op(8'h5A, 8'h3C, 1'b0, 5, rs, rc, lat);
    check("add_5a_3c_sum", 32'(rs), 32'h96);
    check("add_5a_3c_cout", 32'(rc), 32'd0);
    check("latency", 32'(lat), 32'(W));

    // Overflow wraps, carry on cout.
    run_op(8'hFF, 8'h01, 1'b0, 0, rs, rc, lat);
    check("add_ff_01_sum", 32'(rs), 32'h00);
    check("add_ff_01_cout", 32'(rc), 32'd1);

`ifdef SERIAL_ADD_SUB_EN
    run_op(8'h10, 8'h01, 1'b1, 1, rs, rc, lat);
    check("sub_10_01_sum", 32'(rs), 32'h0F);
    check("sub_10_01_cout", 32'(rc), 32'd1);
    run_op(8'h01, 8'h02, 1'b1, 2, rs, rc, lat);
    check("sub_01_02_sum", 32'(rs), 32'hFF);
    check("sub_01_02_cout", 32'(rc), 32'd0);
`else
    // op is ignored: still an add.
    run_op(8'h10, 8'h01, 1'b1, 1, rs, rc, lat);
    check("op_ignored_sum", 32'(rs), 32'h11);
    check("op_ignored_cout", 32'(rc), 32'd0);
`endif

    // Reset in the third RUN cycle aborts the operation.
    @(negedge clk);
    #1;
    in_valid = 1'b1;
    a = 8'h33;
    b = 8'h44;
    op = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_sum", 32'(sum), 32'd0);
    seen = 0;
    repeat (2 * W) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_out_valid", 32'(seen), 32'd0);
    run_op(8'h01, 8'h01, 1'b0, 0, rs, rc, lat);
    check("after_abort_sum", 32'(rs), 32'h02);
    check("after_abort_cout", 32'(rc), 32'd0);

    // Randomized transactions.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rop = 1'($urandom_range(0, 1));
      hold = $urandom_range(0, 3);
      exp = ref_result(ra, rb, rop);
      run_op(ra, rb, rop, hold, rs, rc, lat);
      check("rand_sum", 32'(rs), 32'(exp[W-1:0]));
      check("rand_cout", 32'(rc), 32'(exp[W]));
      check("rand_latency", 32'(lat), 32'(W));
    end

    // Back-to-back: both handshakes tied high, one result per W+2 cycles.
    @(negedge clk);
    #1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    last_t = -1;
    n_res = 0;
    for (int t = 0; t < 6 * (W + 2); t++) begin
      @(negedge clk);
      if (out_valid) begin
        if (last_t >= 0) check("b2b_period", 32'(t - last_t), 32'(W + 2));
        last_t = t;
        n_res++;
      end
      #1;
      a = W'($urandom);
      b = W'($urandom);
      op = 1'($urandom_range(0, 1));
    end
    check("b2b_results", 32'(n_res), 32'd6);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2 * W + 4) @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
